// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and widths for the fetch/PC stage, instruction memory and decoder.
package fetch_pc_unit_pkg;

  localparam int PC_W  = 10;
  localparam int OFF_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_pc_next_adder.sv
// Next-PC adder: PC + 1, or PC + sign-extended offset when i_take is set.
// The sum wraps modulo 2^PC_W. The jump-target logic reuses this block.
module fetch_pc_unit_pc_next_adder #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8
) (
  input  logic [PC_W-1:0]  i_pc,
  input  logic [OFF_W-1:0] i_offset,
  input  logic             i_take,
  output logic [PC_W-1:0]  o_pc_next
);

  logic [PC_W-1:0] w_offset_ext;
  logic [PC_W-1:0] w_step;

  // Signed cast makes the resize replicate the offset's sign bit.
  assign w_offset_ext = PC_W'($signed(i_offset));
  assign w_step       = i_take ? w_offset_ext : PC_W'(1);
  assign o_pc_next    = i_pc + w_step;

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencing with a start/halt/done handshake.
// Optional feature macro: PERF_CNT_EN adds the instr_count and taken_count outputs.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   RUN    | PC holds a live instruction (fetch_valid=1)
//   HALTED | halt retired, done=1, waiting for start
module fetch_pc_unit #(
  parameter int          PC_W     = fetch_pc_unit_pkg::PC_W,
  parameter int unsigned RESET_PC = 0,
  parameter int          OFF_W    = fetch_pc_unit_pkg::OFF_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_en,
  input  logic             branchCompPass,
  input  logic [OFF_W-1:0] branch_offset,
  output logic [PC_W-1:0]  PC,
  output logic             fetch_valid,
  output logic             done
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]      instr_count,
  output logic [15:0]      taken_count
`endif
);

  import fetch_pc_unit_pkg::*;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_adder_pc;
  logic            r_fetch_valid;
  logic            w_fetch_valid_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            w_take;
  logic            w_start_acc;
  logic            w_run_adv;

  assign w_take = branch_en & branchCompPass;

  fetch_pc_unit_pc_next_adder #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_pc_next_adder (
    .i_pc      (r_pc),
    .i_offset  (branch_offset),
    .i_take    (w_take),
    .o_pc_next (w_adder_pc)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_fetch_valid_nxt = r_fetch_valid;
    w_done_nxt        = r_done;
    w_start_acc       = 1'b0;
    w_run_adv         = 1'b0;
    case (r_state)
      IDLE, HALTED: begin
        if (start) begin
          w_state_nxt       = RUN;
          w_pc_nxt          = start_addr;
          w_fetch_valid_nxt = 1'b1;
          w_done_nxt        = 1'b0;
          w_start_acc       = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          w_run_adv = 1'b1;
          // Halt outranks a branch decoded at the same address; PC stays on the halt.
          if (halt) begin
            w_state_nxt       = HALTED;
            w_fetch_valid_nxt = 1'b0;
            w_done_nxt        = 1'b1;
          end else begin
            w_pc_nxt = w_adder_pc;
          end
        end
      end
      default: begin
        w_state_nxt       = IDLE;
        w_fetch_valid_nxt = 1'b0;
        w_done_nxt        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= IDLE;
      r_pc          <= PC_W'(RESET_PC);
      r_fetch_valid <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_done        <= w_done_nxt;
    end
  end

  assign PC          = r_pc;
  assign fetch_valid = r_fetch_valid;
  assign done        = r_done;

`ifdef PERF_CNT_EN
  logic [15:0] r_instr_count;
  logic [15:0] r_taken_count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_instr_count <= '0;
      r_taken_count <= '0;
    end else if (w_start_acc) begin
      r_instr_count <= '0;
      r_taken_count <= '0;
    end else if (w_run_adv) begin
      if (r_instr_count != 16'hFFFF) r_instr_count <= r_instr_count + 16'd1;
      if (!halt && w_take && (r_taken_count != 16'hFFFF))
        r_taken_count <= r_taken_count + 16'd1;
    end
  end

  assign instr_count = r_instr_count;
  assign taken_count = r_taken_count;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed plan cases plus randomized traffic
// checked every cycle against a behavioural model. Honours PERF_CNT_EN when defined.
module tb_fetch_pc_unit;

  localparam int PC_W  = 10;
  localparam int OFF_W = 8;
  localparam int MOD   = 1 << PC_W;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             start = 1'b0;
  logic [PC_W-1:0]  start_addr = '0;
  logic             stall = 1'b0;
  logic             halt = 1'b0;
  logic             branch_en = 1'b0;
  logic             branchCompPass = 1'b0;
  logic [OFF_W-1:0] branch_offset = '0;
  logic [PC_W-1:0]  PC;
  logic             fetch_valid;
  logic             done;
`ifdef PERF_CNT_EN
  logic [15:0]      instr_count;
  logic [15:0]      taken_count;
`endif

  fetch_pc_unit #(.PC_W(PC_W), .RESET_PC(0), .OFF_W(OFF_W)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .start          (start),
    .start_addr     (start_addr),
    .stall          (stall),
    .halt           (halt),
    .branch_en      (branch_en),
    .branchCompPass (branchCompPass),
    .branch_offset  (branch_offset),
    .PC             (PC),
    .fetch_valid    (fetch_valid),
    .done           (done)
`ifdef PERF_CNT_EN
    ,
    .instr_count    (instr_count),
    .taken_count    (taken_count)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: 0 = idle, 1 = running, 2 = halted.
  int m_mode = 0;
  int m_pc   = 0;
  int m_ic   = 0;
  int m_tc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int off;
    if (m_mode == 1) begin
      if (!stall) begin
        if (m_ic < 65535) m_ic++;
        if (halt) begin
          m_mode = 2;
        end else if (branch_en && branchCompPass) begin
          off  = int'($signed(branch_offset));
          m_pc = ((m_pc + off) % MOD + MOD) % MOD;
          if (m_tc < 65535) m_tc++;
        end else begin
          m_pc = (m_pc + 1) % MOD;
        end
      end
    end else if (start) begin
      m_mode = 1;
      m_pc   = int'(start_addr);
      m_ic   = 0;
      m_tc   = 0;
    end
  endtask

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_mode = 0;
      m_pc   = 0;
      m_ic   = 0;
      m_tc   = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("pc", 32'(PC), 32'(m_pc));
      chk("fetch_valid", 32'(fetch_valid), 32'(m_mode == 1));
      chk("done", 32'(done), 32'(m_mode == 2));
`ifdef PERF_CNT_EN
      chk("instr_count", 32'(instr_count), 32'(m_ic));
      chk("taken_count", 32'(taken_count), 32'(m_tc));
`endif
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic clear_ctl();
    start = 0; stall = 0; halt = 0; branch_en = 0; branchCompPass = 0; branch_offset = '0;
  endtask

  // Brings the DUT into RUN at addr, halting first if it is already running.
  task automatic go(input logic [PC_W-1:0] addr);
    clear_ctl();
    if (m_mode == 1) begin
      halt = 1; step(); halt = 0;
    end
    start_addr = addr; start = 1; step(); start = 0;
  endtask

  task automatic branch(input logic pass, input logic [7:0] off);
    branch_en = 1; branchCompPass = pass; branch_offset = off;
    step();
    branch_en = 0; branchCompPass = 0; branch_offset = '0;
  endtask

  initial begin
    clear_ctl();
    repeat (2) step();
    chk("reset_pc", 32'(PC), 32'h000);
    chk("reset_valid", 32'(fetch_valid), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    RST_N = 1;
    chk_en = 1;
    step();
    chk("idle_hold_pc", 32'(PC), 32'h000);

    // Start and sequential fetch
    start_addr = 10'h010; start = 1; step(); start = 0;
    chk("start_pc", 32'(PC), 32'h010);
    chk("start_valid", 32'(fetch_valid), 32'd1);
    step(); chk("inc1", 32'(PC), 32'h011);
    step(); chk("inc2", 32'(PC), 32'h012);

    // Branch taken backward, and not taken
    go(10'h020); branch(1'b1, 8'hFC); chk("br_taken_back", 32'(PC), 32'h01C);
    go(10'h020); branch(1'b0, 8'hFC); chk("br_not_taken", 32'(PC), 32'h021);

    // Wrap cases
    go(10'h3FF); step(); chk("wrap_inc", 32'(PC), 32'h000);
    go(10'h3FF); branch(1'b1, 8'h02); chk("wrap_fwd", 32'(PC), 32'h001);
    go(10'h000); branch(1'b1, 8'h80); chk("wrap_neg", 32'(PC), 32'h380);
    go(10'h123); branch(1'b1, 8'h00); chk("self_loop", 32'(PC), 32'h123);

    // Stall beats halt, then halt, then restart from HALTED
    go(10'h030);
    stall = 1; halt = 1; step();
    chk("stall_pc", 32'(PC), 32'h030);
    chk("stall_done", 32'(done), 32'd0);
    stall = 0; step();
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_valid", 32'(fetch_valid), 32'd0);
    chk("halt_pc", 32'(PC), 32'h030);
    halt = 0; step();
    chk("halted_hold_pc", 32'(PC), 32'h030);
    start_addr = 10'h005; start = 1; step(); start = 0;
    chk("restart_pc", 32'(PC), 32'h005);
    chk("restart_done", 32'(done), 32'd0);

    // Halt and taken branch together: halt wins
    go(10'h050);
    halt = 1; branch_en = 1; branchCompPass = 1; branch_offset = 8'h10; step();
    clear_ctl();
    chk("halt_vs_br_pc", 32'(PC), 32'h050);
    chk("halt_vs_br_done", 32'(done), 32'd1);

    // Asynchronous reset mid-RUN
    go(10'h044);
    chk("pre_reset_pc", 32'(PC), 32'h044);
    #2 RST_N = 0;
    #1;
    chk("async_pc", 32'(PC), 32'h000);
    chk("async_valid", 32'(fetch_valid), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    step();
    #2 RST_N = 1;
    repeat (3) step();
    chk("post_reset_pc", 32'(PC), 32'h000);
    chk("post_reset_valid", 32'(fetch_valid), 32'd0);

`ifdef PERF_CNT_EN
    go(10'h100);
    step();
    branch(1'b1, 8'h02);
    step();
    branch(1'b1, 8'h03);
    step();
    halt = 1; step(); halt = 0;
    chk("perf_instr", 32'(instr_count), 32'd6);
    chk("perf_taken", 32'(taken_count), 32'd2);
    start_addr = 10'h000; start = 1; step(); start = 0;
    chk("perf_clr_instr", 32'(instr_count), 32'd0);
    chk("perf_clr_taken", 32'(taken_count), 32'd0);
`endif

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      start          = ($urandom_range(0, 99) < 15);
      start_addr     = ($urandom_range(0, 3) == 0) ? PC_W'(10'h3F0 + $urandom_range(0, 15))
                                                   : PC_W'($urandom);
      stall          = (m_mode == 1) && ($urandom_range(0, 99) < 20);
      halt           = ($urandom_range(0, 99) < 8);
      branch_en      = ($urandom_range(0, 99) < 40);
      branchCompPass = $urandom_range(0, 1) == 1;
      branch_offset  = OFF_W'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 RST_N = 0;
        step();
        #2 RST_N = 1;
      end else begin
        step();
      end
    end
    clear_ctl();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
